board_io_ctrl: RTL and testbench

Board-level I/O controller for the NVBoard top level. It drives 16 status LEDs as a rotating light, runs a rotating 8-digit seven-segment demo, and receives PS/2 keyboard frames into an 8-entry FIFO. All logic runs in the single system clock domain; the PS/2 lines are asynchronous inputs and are synchronized internally.

---
 rtl/board_io_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_board_io_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O controller: rotating LEDs, rotating 7-seg demo,
// PS/2 keyboard receiver feeding an 8-entry scan-code FIFO.
module board_io_ctrl #(
  parameter int LED_PERIOD = 5000000,
  parameter int SEG_PERIOD = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        kbd_next,
  output logic [15:0] ledr,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7,
  output logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        kbd_overflow
);

  localparam int LW = $clog2(LED_PERIOD);
  localparam int SW = $clog2(SEG_PERIOD);
  localparam logic [LW-1:0] LMAX = LW'(LED_PERIOD - 1);
  localparam logic [SW-1:0] SMAX = SW'(SEG_PERIOD - 1);

  logic [LW-1:0] lc_q, lc_d;
  logic [15:0]   led_q, led_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [2:0]    off_q, off_d;

  logic [2:0]    s_q;
  logic [1:0]    dsy_q;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          push_q, push_d;
  logic [7:0]    pdat_q, pdat_d;
  logic          fall, bit_in;

  logic [7:0]    mem_q [8];
  logic [2:0]    rd_q, rd_d, wr_q, wr_d;
  logic [3:0]    n_q, n_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, wr_en;

  // Active-low digit glyphs, dp off
  function automatic logic [7:0] seg_code(input logic [2:0] d);
    seg_code = 8'hFF;
    unique case (d)
      3'd0: seg_code = 8'h03;
      3'd1: seg_code = 8'h9F;
      3'd2: seg_code = 8'h25;
      3'd3: seg_code = 8'h0D;
      3'd4: seg_code = 8'h99;
      3'd5: seg_code = 8'h49;
      3'd6: seg_code = 8'h41;
      3'd7: seg_code = 8'h1F;
    endcase
  endfunction

  // Period counters advance the LED ring and the digit offset
  always_comb begin
    lc_d  = lc_q + LW'(1);
    led_d = led_q;
    sc_d  = sc_q + SW'(1);
    off_d = off_q;
    if (lc_q == LMAX) begin
      lc_d  = '0;
      led_d = {led_q[14:0], led_q[15]};
    end
    if (sc_q == SMAX) begin
      sc_d  = '0;
      off_d = off_q + 3'd1;
    end
  end

  // Display state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lc_q  <= '0;
      led_q <= 16'h0001;
      sc_q  <= '0;
      off_q <= '0;
    end else begin
      lc_q  <= lc_d;
      led_q <= led_d;
      sc_q  <= sc_d;
      off_q <= off_d;
    end
  end

  assign ledr = rst ? {8'h00, sw} : led_q;
  assign seg0 = seg_code(off_q + 3'd0);
  assign seg1 = seg_code(off_q + 3'd1);
  assign seg2 = seg_code(off_q + 3'd2);
  assign seg3 = seg_code(off_q + 3'd3);
  assign seg4 = seg_code(off_q + 3'd4);
  assign seg5 = seg_code(off_q + 3'd5);
  assign seg6 = seg_code(off_q + 3'd6);
  assign seg7 = seg_code(off_q + 3'd7);

  // PS/2 line synchronizers, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 3'b111;
      dsy_q <= 2'b11;
    end else begin
      s_q   <= {s_q[1:0], ps2_clk};
      dsy_q <= {dsy_q[0], ps2_data};
    end
  end

  assign fall   = s_q[2] & ~s_q[1];
  assign bit_in = dsy_q[1];

  // Frame assembly; the 11th bit is the stop bit and closes the frame
  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    push_d = 1'b0;
    pdat_d = pdat_q;
    if (fall) begin
      if (cnt_q == 4'd10) begin
        cnt_d  = '0;
        pdat_d = sh_q[8:1];
        push_d = ~sh_q[0] & bit_in & (^sh_q[9:1]);
      end else begin
        sh_d[cnt_q] = bit_in;
        cnt_d       = cnt_q + 4'd1;
      end
    end
  end

  // Receiver registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      push_q <= 1'b0;
      pdat_q <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      push_q <= push_d;
      pdat_q <= pdat_d;
    end
  end

  assign pop   = kbd_next & (n_q != 4'd0);
  assign full  = (n_q == 4'd8);
  assign wr_en = push_q & (~full | pop);

  // FIFO pointers; a pop frees the slot for a same-cycle push
  always_comb begin
    rd_d  = rd_q + 3'(pop);
    wr_d  = wr_q + 3'(wr_en);
    n_d   = n_q + 4'(wr_en) - 4'(pop);
    ovf_d = ovf_q | (push_q & ~wr_en);
  end

  // FIFO storage and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      n_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_q] <= pdat_q;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      n_q   <= n_d;
      ovf_q <= ovf_d;
    end
  end

  assign kbd_data     = mem_q[rd_q];
  assign kbd_ready    = (n_q != 4'd0);
  assign kbd_overflow = ovf_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: display tables,
// PS/2 corner sequences and random frames vs a queue model.
module tb_board_io_ctrl;
  localparam int LP = 4;
  localparam int SP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        kbd_next = 1'b0;
  logic [15:0] ledr;
  logic [7:0]  seg [8];
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        kbd_overflow;

  board_io_ctrl #(.LED_PERIOD(LP), .SEG_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_next(kbd_next), .ledr(ledr),
    .seg0(seg[0]), .seg1(seg[1]), .seg2(seg[2]),
    .seg3(seg[3]), .seg4(seg[4]), .seg5(seg[5]),
    .seg6(seg[6]), .seg7(seg[7]),
    .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] led;
    logic [7:0]  s0;
    logic [7:0]  s7;
  } vec_t;

  vec_t       tv [7];
  logic [7:0] code [8];
  logic [7:0] q [$];
  bit         ovf_m;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] swv);
    @(negedge clk);
    rst = 1'b1;
    sw = swv;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    kbd_next = 1'b0;
    repeat (2) @(negedge clk);
    chk("ledr_in_rst", ledr, {8'h00, swv});
    chk("ovf_in_rst", kbd_overflow, 0);
    chk("ready_in_rst", kbd_ready, 0);
    chk("data_in_rst", kbd_data, 0);
    rst = 1'b0;
    q.delete();
    ovf_m = 1'b0;
  endtask

  task automatic run_table();
    int cur = 0;
    for (int i = 0; i < 7; i++) begin
      repeat (tv[i].cyc - cur) @(negedge clk);
      cur = tv[i].cyc;
      #1;
      chk($sformatf("tv%0d_ledr", i), ledr, tv[i].led);
      chk($sformatf("tv%0d_seg0", i), seg[0], tv[i].s0);
      chk($sformatf("tv%0d_seg7", i), seg[7], tv[i].s7);
    end
  endtask

  task automatic chk_disp(input int k);
    chk("rnd_ledr", ledr, 16'h1 << ((k / LP) % 16));
    for (int i = 0; i < 8; i++)
      chk($sformatf("rnd_seg%0d", i), seg[i], code[(i + k / SP) % 8]);
  endtask

  task automatic mpush(input logic [7:0] d);
    if (q.size() == 8) ovf_m = 1'b1;
    else q.push_back(d);
  endtask

  task automatic chk_fifo(input string nm);
    chk({nm, "_ready"}, kbd_ready, q.size() != 0);
    if (q.size() != 0) chk({nm, "_data"}, kbd_data, q[0]);
    chk({nm, "_ovf"}, kbd_overflow, ovf_m);
  endtask

  task automatic pop_one();
    @(negedge clk);
    kbd_next = 1'b1;
    @(negedge clk);
    kbd_next = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input bit bad_stop, input int h,
                            input int nbits, input bit lat,
                            input bit popat);
    logic [10:0] fr;
    fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      ps2_data = fr[b];
      repeat (h - 1) @(negedge clk);
      ps2_clk = 1'b0;
      if (b == 10 && lat) begin
        repeat (3) @(posedge clk);
        #1 chk("lat_edge3", kbd_ready, 0);
        @(posedge clk);
        #1 chk("lat_edge4", kbd_ready, 1);
      end
      if (b == 10 && popat) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        kbd_next = 1'b1;
        @(negedge clk);
        kbd_next = 1'b0;
      end
      repeat (h) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (h) @(negedge clk);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    logic [7:0] d;
    bit bp, bs;
    code = '{8'h03, 8'h9F, 8'h25, 8'h0D,
             8'h99, 8'h49, 8'h41, 8'h1F};
    tv[0] = '{0,  16'h0001, 8'h03, 8'h1F};
    tv[1] = '{3,  16'h0001, 8'h9F, 8'h03};
    tv[2] = '{4,  16'h0002, 8'h9F, 8'h03};
    tv[3] = '{6,  16'h0002, 8'h25, 8'h9F};
    tv[4] = '{8,  16'h0004, 8'h25, 8'h9F};
    tv[5] = '{24, 16'h0040, 8'h03, 8'h1F};
    tv[6] = '{64, 16'h0001, 8'h49, 8'h99};

    do_reset(8'hA5);
    run_table();
    repeat (7 + $urandom % 5) @(negedge clk);
    do_reset(8'h3C);
    run_table();

    do_reset(8'($urandom));
    k = 0;
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(1, 40);
      repeat (n) @(negedge clk);
      k += n;
      #1 chk_disp(k);
    end

    do_reset(8'h00);
    send_frame(8'h1C, 0, 0, 10, 11, 1, 0);
    mpush(8'h1C);
    chk_fifo("single");
    pop_one();
    chk_fifo("single_pop");

    send_frame(8'h1C, 1, 0, 10, 11, 0, 0);
    send_frame(8'h55, 0, 1, 10, 11, 0, 0);
    chk_fifo("bad_frames");
    send_frame(8'hA7, 0, 0, 6, 11, 0, 0);
    mpush(8'hA7);
    chk_fifo("after_bad");

    send_frame(8'hFF, 0, 0, 10, 5, 0, 0);
    do_reset(8'h00);
    send_frame(8'h3A, 0, 0, 5, 11, 0, 0);
    mpush(8'h3A);
    chk_fifo("mid_frame_rst");

    do_reset(8'h00);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 0, 0, 4, 11, 0, 0);
      mpush(8'(i));
    end
    chk_fifo("ovf_full");
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_order%0d", i), kbd_data, i);
      pop_one();
    end
    chk_fifo("ovf_drained");
    chk("ovf_sticky", kbd_overflow, 1);
    do_reset(8'h00);

    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0, 4, 11, 0, 0);
      mpush(8'h10 + 8'(i));
    end
    send_frame(8'h20, 0, 0, 4, 11, 0, 1);
    void'(q.pop_front());
    q.push_back(8'h20);
    chk_fifo("simul");
    for (int i = 0; i < 8; i++) begin
      pop_one();
      chk_fifo($sformatf("simul_pop%0d", i));
    end

    do_reset(8'h00);
    for (int i = 0; i < 40; i++) begin
      if ($urandom % 3 == 0) begin
        pop_one();
      end else begin
        d = 8'($urandom);
        bp = ($urandom % 6 == 0);
        bs = ($urandom % 6 == 0);
        send_frame(d, bp, bs, $urandom_range(4, 8), 11, 0, 0);
        if (!bp && !bs) mpush(d);
      end
      chk_fifo($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
